// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 64-bit memory between the instruction
// fetch port (i_*) and the load/store port (d_*) of the core.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req/i_addr                fetch request (valid/ready handshake)
//   i_ready                     fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata            fetch read data, one cycle after accept
//   d_req/d_we/d_lock           data request, store select, keep-grant lock
//   d_addr/d_wdata              data address and store data
//   d_ready                     data accepted this cycle (combinational)
//   d_rvalid/d_rdata            load data, one cycle after accept
//   mem_address/mem_wdata       memory address / write data
//   mem_read/mem_write          memory enables
//   mem_rdata                   combinational memory read data
//
// Data wins by default; a fetch that has been denied STARVE_LIMIT cycles in a
// row is forced through, except while an atomic (locked) sequence is active.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_lock,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic [63:0] mem_address,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        i_gnt, d_gnt;
  logic        i_rvalid_q, d_rvalid_q;
  logic [63:0] i_rdata_q, d_rdata_q;

  // Grant selection and next-state logic.
  always_comb begin
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    if (state_q == LOCKED) begin
      // Atomic sequence owns the memory; starvation override is suppressed.
      d_gnt = d_req;
    end else if (starve_cnt_q == LIMIT && i_req) begin
      i_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else if (i_req) begin
      i_gnt = 1'b1;
    end

    // Counter keeps running while locked so the fetch wins right after unlock.
    if (!i_req || i_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Each accepted data access decides whether the lock is held afterwards.
    if (d_gnt) begin
      state_d = d_lock ? LOCKED : IDLE;
    end
  end

  // Memory drive: everything is zero when nobody is granted.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if (i_gnt) begin
      mem_address = i_addr;
      mem_read    = 1'b1;
    end else if (d_gnt) begin
      mem_address = d_addr;
      mem_wdata   = d_wdata;
      mem_read    = ~d_we;
      mem_write   = d_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      i_rvalid_q   <= i_gnt;
      d_rvalid_q   <= d_gnt & ~d_we;
      if (i_gnt) begin
        i_rdata_q <= mem_rdata;
      end
      if (d_gnt && !d_we) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign i_ready  = i_gnt;
  assign d_ready  = d_gnt;
  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a small memory device plus a transaction-level
// reference model (pending-fetch wait count, lock flag, expected memory image).
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, d_lock;
  logic [63:0] i_addr, d_addr, d_wdata;
  logic        i_ready, i_rvalid, d_ready, d_rvalid;
  logic [63:0] i_rdata, d_rdata;
  logic [63:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // 16-word memory device: combinational read, write on the rising edge.
  logic [63:0] mem_arr [16] = '{default: 64'd0};
  assign mem_rdata = mem_arr[mem_address[3:0]];
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_address[3:0]] <= mem_wdata;
  end

  // Reference model state.
  logic [63:0] ref_mem [16] = '{default: 64'd0};
  bit          ref_locked;
  int          ref_wait;
  bit          exp_irv, exp_drv;
  logic [63:0] exp_ird, exp_drd;
  bit          obs_i_ready, obs_d_ready;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    ref_locked = 1'b0;
    ref_wait   = 0;
    exp_irv    = 1'b0;
    exp_drv    = 1'b0;
    exp_ird    = '0;
    exp_drd    = '0;
  endtask

  // One clock cycle: check combinational grant/memory drive mid-cycle,
  // advance the model at the edge, then check registered read data.
  task automatic cycle(output bit fg, output bit dg);
    logic [63:0] ea;
    @(negedge clk);
    fg = i_req && !ref_locked && (ref_wait == LIMIT || !d_req);
    dg = d_req && !fg;
    obs_i_ready = i_ready;
    obs_d_ready = d_ready;
    chk("i_ready", i_ready, fg);
    chk("d_ready", d_ready, dg);
    ea = fg ? i_addr : (dg ? d_addr : 64'd0);
    chk("mem_address", mem_address, ea);
    chk("mem_read", mem_read, fg || (dg && !d_we));
    chk("mem_write", mem_write, dg && d_we);
    if (dg && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    else if (!fg && !dg) chk("mem_wdata_idle", mem_wdata, 64'd0);
    @(posedge clk);
    exp_irv = fg;
    exp_drv = dg && !d_we;
    if (fg) exp_ird = ref_mem[i_addr[3:0]];
    if (exp_drv) exp_drd = ref_mem[d_addr[3:0]];
    if (dg && d_we) ref_mem[d_addr[3:0]] = d_wdata;
    if (dg) ref_locked = d_lock;
    if (!i_req || fg) ref_wait = 0;
    else if (ref_wait < LIMIT) ref_wait++;
    #1;
    chk("i_rvalid", i_rvalid, exp_irv);
    chk("d_rvalid", d_rvalid, exp_drv);
    chk("i_rdata", i_rdata, exp_ird);
    chk("d_rdata", d_rdata, exp_drd);
  endtask

  task automatic no_req();
    i_req = 0; d_req = 0; d_we = 0; d_lock = 0;
  endtask

  task automatic set_d(input bit we, input bit lk, input logic [63:0] a, input logic [63:0] wd);
    d_req = 1; d_we = we; d_lock = lk; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    bit fg, dg;
    rst_n = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    no_req();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Single fetch of 0xAA from address 5 (preloaded by a store).
    set_d(1, 0, 64'd5, 64'hAA);
    cycle(fg, dg);
    no_req(); i_req = 1; i_addr = 64'd5;
    cycle(fg, dg);
    chk("fetch_ready", obs_i_ready, 1);
    chk("fetch_rvalid", i_rvalid, 1);
    chk("fetch_rdata", i_rdata, 64'hAA);
    no_req();
    cycle(fg, dg);
    chk("fetch_after_read", mem_read, 0);

    // Store then load on the next cycle.
    set_d(1, 0, 64'd7, 64'h1234);
    cycle(fg, dg);
    set_d(0, 0, 64'd7, 64'd0);
    cycle(fg, dg);
    no_req();
    cycle(fg, dg);
    chk("stld_rvalid", d_rvalid, 0);
    chk("stld_rdata", d_rdata, 64'h1234);

    // Contention: data 4 cycles, then fetch, repeating.
    i_req = 1; i_addr = 64'd5;
    set_d(0, 0, 64'd7, 64'd0);
    for (int k = 0; k < 15; k++) begin
      cycle(fg, dg);
      chk("contend_fetch", obs_i_ready, (k % 5) == 4);
      chk("contend_data", obs_d_ready, (k % 5) != 4);
    end
    no_req();
    cycle(fg, dg);

    // Lock: fetch stays blocked past the starvation limit until unlock.
    i_req = 1; i_addr = 64'd3;
    set_d(0, 1, 64'd5, 64'd0);
    cycle(fg, dg);
    chk("lock_first_d", obs_d_ready, 1);
    d_req = 0; d_lock = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(fg, dg);
      chk("lock_block_i", obs_i_ready, 0);
    end
    set_d(1, 0, 64'd9, 64'h55);
    cycle(fg, dg);
    chk("unlock_store", obs_d_ready, 1);
    chk("unlock_block_i", obs_i_ready, 0);
    d_req = 0;
    cycle(fg, dg);
    chk("after_unlock_i", obs_i_ready, 1);
    no_req();
    cycle(fg, dg);

    // Reset mid-read: once with a locked load pending, once with a fetch.
    for (int r = 0; r < 2; r++) begin
      if (r == 0) set_d(0, 1, 64'd7, 64'd0);
      else begin i_req = 1; i_addr = 64'd5; end
      cycle(fg, dg);
      rst_n = 0;
      no_req();
      #1;
      chk("rst_mid_i_rvalid", i_rvalid, 0);
      chk("rst_mid_d_rvalid", d_rvalid, 0);
      chk("rst_mid_mem_read", mem_read, 0);
      chk("rst_mid_mem_write", mem_write, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      @(posedge clk); #1;
      i_req = 1; i_addr = 64'd9;
      cycle(fg, dg);
      chk("rst_mid_idle_grant", obs_i_ready, 1);
      no_req();
    end

    // Idle for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      cycle(fg, dg);
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_mem_address", mem_address, 0);
    end

    // Randomized traffic; requests held until accepted.
    fg = 1; dg = 1;
    repeat (500) begin
      if (fg || !i_req) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 64'($urandom_range(0, 15));
      end
      if (dg || !d_req) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_lock  = ($urandom_range(0, 4) == 0);
        d_addr  = 64'($urandom_range(0, 15));
        d_wdata = {$urandom, $urandom};
      end
      cycle(fg, dg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
